// File: rtl/dec_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared types and widths for the pipelined 2-to-4 decoder.
//   CODE_W      : width of the binary input code
//   OUT_W       : width of the decoded one-hot word
//   CNT_W       : width of the accepted-code counter
//   occ_state_e : FIFO occupancy state (EMPTY / ONE / FULL)
// -----------------------------------------------------------------------------
package dec_pkg;

  localparam int CODE_W = 2;
  localparam int OUT_W  = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

endpackage : dec_pkg

// File: rtl/dec_2x4_core.sv
// -----------------------------------------------------------------------------
// dec_2x4_core
// Purely combinational 2-to-4 decoder with optional active-low output.
// Parameters:
//   ACT_LOW : 1 inverts the one-hot word so exactly one bit reads 0
// Ports:
//   code    : in  [CODE_W-1:0] binary code
//   y       : out [OUT_W-1:0]  decoded word (one-hot, or one-cold if ACT_LOW)
// -----------------------------------------------------------------------------
module dec_2x4_core
  import dec_pkg::*;
#(
  parameter bit ACT_LOW = 1'b0
) (
  input  logic [CODE_W-1:0] code,
  output logic [OUT_W-1:0]  y
);

  logic [OUT_W-1:0] onehot;

  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a value on
    // all paths (here by an unconditional first assignment) so no latch forms.
    onehot = '0;
    onehot[code] = 1'b1;
    y = ACT_LOW ? ~onehot : onehot;
  end

endmodule : dec_2x4_core

// File: rtl/dec_2x4_pipe.sv
// -----------------------------------------------------------------------------
// dec_2x4_pipe
// Valid/ready 2-to-4 decoder feeding a 2-entry FIFO. Every output is driven
// straight from a flop, so there is no combinational path from in_* to out_*.
// Parameters:
//   ACT_LOW   : 1 inverts the decoded word (idle level becomes 4'b1111)
// Ports:
//   clk       : in  system clock, rising edge
//   rst       : in  asynchronous active-high reset
//   in_valid  : in  upstream code valid
//   in_code   : in  [CODE_W-1:0] code to decode
//   in_ready  : out block accepts a code this cycle (registered, state only)
//   out_valid : out out_y holds a decoded word
//   out_y     : out [OUT_W-1:0] decoded word, inactive level when empty
//   out_ready : in  downstream consumes out_y this cycle
//   cnt       : out [CNT_W-1:0] saturating count of accepted codes
// Configuration:
//   DEC_2X4_PIPE_CNT_EN : when defined, cnt counts accepted codes and
//                         saturates at all-ones; otherwise cnt is tied to 0.
// -----------------------------------------------------------------------------
module dec_2x4_pipe
  import dec_pkg::*;
#(
  parameter bit ACT_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_y,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  cnt
);

  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACT_LOW}};

  occ_state_e       state_q, state_d;
  logic [OUT_W-1:0] head_q, head_d;   // word presented on out_y
  logic [OUT_W-1:0] tail_q, tail_d;   // second word, valid only in FULL
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] dec_word;
  logic             push, pop;

  dec_2x4_core #(.ACT_LOW(ACT_LOW)) u_core (
    .code (in_code),
    .y    (dec_word)
  );

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // ---------------------------------------------------------------------------
  // State register (FSM process 1) plus the flops it shares a reset with.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      // NOTE: both storage words are reset: head must show the idle level out
      // of reset, and clearing tail guarantees no pre-reset word survives.
      head_q      <= INACTIVE;
      tail_q      <= INACTIVE;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic (FSM process 2). A push in FULL cannot happen because
  // in_ready is low there.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
      end
      FULL:  if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (FSM process 3). Handshake flags are computed from the next
  // state and registered, so they depend on the current state only.
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // ---------------------------------------------------------------------------
  // FIFO storage: a two-word shift structure. head is always the oldest word;
  // on a pop from FULL the tail word moves up. When the FIFO drains, head is
  // reloaded with the idle level so out_y needs no output mux.
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    unique case (state_q)
      EMPTY: if (push) head_d = dec_word;
      ONE: begin
        if (push && pop) head_d = dec_word;
        else if (push)   tail_d = dec_word;
        else if (pop)    head_d = INACTIVE;
      end
      FULL: if (pop) head_d = tail_q;
      default: head_d = INACTIVE;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = head_q;

  // ---------------------------------------------------------------------------
  // Accepted-code counter
  // ---------------------------------------------------------------------------
`ifdef DEC_2X4_PIPE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
`else
  assign cnt = '0;
`endif

endmodule : dec_2x4_pipe
